// File: rtl/ctlb_walk.sv
// ctlb_walk: three-level page-table walker that refills the code TLB.
// Keeps at most one memory read in flight and delivers the leaf PTE as a single write pulse.
`ifndef ctlbData_width
`define ctlbData_width 64
`endif

module ctlb_walk #(
    parameter int TIMEOUT       = 255,
    parameter int OUTDATA_WIDTH = `ctlbData_width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_en,
    input  logic [64:0]              miss_addr,
    input  logic                     miss_jump,
    input  logic [43:0]              ptbase,
    input  logic                     flush,
    output logic                     req_en,
    output logic [43:0]              req_addr,
    input  logic                     req_ready,
    input  logic                     resp_en,
    input  logic [63:0]              resp_data,
    input  logic                     resp_err,
    output logic                     write_wen,
    output logic [64:0]              write_addr,
    output logic                     write_tr,
    output logic [OUTDATA_WIDTH-1:0] write_data,
    output logic                     busy,
    output logic                     fault,
    output logic [1:0]               fault_code
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FAULT} state_t;

    state_t             state, state_d;
    logic [1:0]         level;
    logic [40:0]        tbl;
    logic [9:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic               stale;
    logic               tmo_hit;
    logic               stale_set;
    logic [1:0]         code_d;
    logic               unused_bits;

    assign unused_bits = ^ptbase[2:0];

    always_comb begin
        case (level)
            2'd1:    idx = write_addr[43:34];
            2'd2:    idx = write_addr[33:24];
            2'd3:    idx = write_addr[23:14];
            default: idx = '0;
        endcase
    end

    assign req_addr = {tbl + {31'd0, idx}, 3'b000};
    assign tmo_hit  = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state;
        code_d    = fault_code;
        req_en    = 1'b0;
        write_wen = 1'b0;
        fault     = 1'b0;
        case (state)
            IDLE: begin
                if (miss_en && (miss_addr[43:40] != 4'b1110))
                    state_d = REQ;
            end
            REQ: begin
                // An abandoned request must drain before a new one is issued.
                req_en = !stale;
                if (req_en && req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (resp_en) begin
                    if (resp_err) begin
                        state_d = FAULT;
                        code_d  = 2'b10;
                    end else if (!resp_data[0]) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end else if (level != 2'd3) begin
                        state_d = REQ;
                    end else begin
                        state_d = WRITE;
                    end
                end else if (tmo_hit) begin
                    state_d = FAULT;
                    code_d  = 2'b11;
                end
            end
            WRITE: begin
                write_wen = !flush;
                state_d   = IDLE;
            end
            FAULT: begin
                fault   = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    // A request left outstanding by a flush or timeout; its eventual response is dropped.
    assign stale_set = ((state == REQ) && req_en && req_ready && flush) ||
                       ((state == WAIT) && !resp_en && (flush || tmo_hit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            level      <= '0;
            tbl        <= '0;
            cnt        <= '0;
            stale      <= 1'b0;
            busy       <= 1'b0;
            fault_code <= '0;
            write_addr <= '0;
            write_tr   <= 1'b0;
            write_data <= '0;
        end else begin
            state <= state_d;
            busy  <= (state_d != IDLE);
            if (stale_set)
                stale <= 1'b1;
            else if (resp_en)
                stale <= 1'b0;
            if ((state == IDLE) && (state_d == REQ)) begin
                write_addr <= miss_addr;
                write_tr   <= miss_jump;
                tbl        <= ptbase[43:3];
                level      <= 2'd1;
            end
            if ((state == REQ) && (state_d == WAIT))
                cnt <= '0;
            else if ((state == WAIT) && !resp_en)
                cnt <= cnt + 1'b1;
            if ((state == WAIT) && (state_d == REQ)) begin
                tbl   <= {resp_data[43:14], 11'd0};
                level <= level + 2'd1;
            end
            if (state_d == WRITE)
                write_data <= resp_data[OUTDATA_WIDTH-1:0];
            if (state_d == FAULT)
                fault_code <= code_d;
        end
    end

endmodule
